apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Converts single-cycle CPU load/store requests into APB3 transfers for up to 4 memory-mapped peripherals: FND counter, GPIO, timer, UART.
- Sits directly upstream of the APB slave interfaces. It drives the shared PADDR/PWDATA/PWRITE/PENABLE lines and one PSEL per slave, then returns read data and completion to the CPU.
- Includes address decoding, a response mux and a wait-state timeout so that a missing or hung slave cannot stall the core.

Parameters:
- BASE_ADDR, 32'h1000_0000, start of the peripheral region.
- SLV_SIZE_LOG2, 12, log2 of the 4 KB window per slave.
- TIMEOUT_CYC, 16, maximum ACCESS-phase cycles waiting for PREADY before an error response.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset
- transfer  in  1  CPU request strobe, sampled only in IDLE
- write  in  1  1 = write, 0 = read
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, valid when ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  qualifies ready: decode miss or timeout
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB access phase
- PSEL  out  4  one-hot slave select
- PRDATA0..PRDATA3  in  32 each  slave read data
- PREADY0..PREADY3  in  1 each  slave ready

Behaviour:
- Reset: PRESET is asynchronous, active-high; clock is PCLK. On reset, all outputs are 0, FSM goes to IDLE, and the timeout counter goes to 0.
- Reset mid-transfer: abort immediately. No ready pulse follows.
- FSM states are IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If transfer=1 at a rising edge: latch addr, wdata and write into PADDR, PWDATA and PWRITE; latch the decoded index; go to SETUP.
- Address decode:
  - idx = (addr - BASE_ADDR) >> SLV_SIZE_LOG2.
  - Hit when addr >= BASE_ADDR and idx < 4.
  - A miss skips the APB cycle: next cycle is IDLE with ready=1, err=1, rdata=0. PSEL is never asserted.
- SETUP (exactly 1 cycle): PSEL[idx]=1, PENABLE=0. Always goes to ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1. The timeout counter increments each cycle.
  - If PREADY[idx]=1 at an edge: capture PRDATA[idx] into rdata (reads only; writes give rdata=0). Then go to IDLE, with ready=1 and err=0 for that one IDLE cycle.
  - Counter reaches TIMEOUT_CYC with no PREADY: go to IDLE with ready=1, err=1, rdata=0.
- PREADY/PRDATA from non-selected slaves are ignored.
- ready and err are registered, high for exactly one cycle, then cleared.
- rdata holds its value until the next completion.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the end of ACCESS. They hold their last values while in IDLE.
- Latency: transfer sampled at edge k gives SETUP in cycle k+1 and ACCESS in cycle k+2.
  - Zero-wait slave: ready in cycle k+3.
  - Each extra PREADY-low cycle adds 1.
  - The registered-PREADY slaves in this SoC (FND, GPIO) give ready in cycle k+4.
- transfer asserted outside IDLE, including in the ready cycle's IDLE: a new request is accepted only when sampled in IDLE. The CPU holds transfer low until ready, so back-to-back requests are possible on the cycle after ready.
- Timeout counter clears on entry to SETUP. Width is $clog2(TIMEOUT_CYC+1).

Test Plan:
- Write 0x0000_04D2 to 0x1000_0004 (slave 0 FND FDR):
  - PSEL=4'b0001, SETUP then ACCESS, PWRITE=1, PWDATA=0x4D2.
  - ready at k+4, err=0.
  - Slave register reads back 1234.
- Read 0x1000_0008 after writing 0x5 there:
  - PWRITE=0, rdata=0x0000_0005 on the ready cycle, err=0.
  - rdata held afterwards.
- Access 0x1000_4000 (idx=4) and 0x0FFF_FFFC:
  - PSEL never asserts.
  - ready and err=1 at k+1, rdata=0.
- Stub slave 3 with PREADY tied 0, read 0x1000_3000:
  - PENABLE stays high for 16 cycles.
  - Then ready=1, err=1, rdata=0; PSEL returns to 0.
- Stub slave 1 with 3 wait states, PRDATA1=0xDEADBEEF, with PRDATA0 driven 0x12345678 and PREADY0=1 throughout:
  - rdata=0xDEADBEEF, ready at k+6, err=0.
- Assert PRESET during ACCESS:
  - PSEL, PENABLE and ready go to 0 asynchronously; no ready pulse.
  - The next transfer completes normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// APB3 bus bundle between the bridge and its four peripheral slaves.
interface apb_master_bridge_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3
    );
endinterface

// File: rtl/apb_master_bridge.sv
// CPU load/store to APB3 bridge for four 4 KB peripheral windows, with
// address decode, response mux and an ACCESS-phase timeout.
module apb_master_bridge #(
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter int unsigned SLV_SIZE_LOG2 = 12,
    parameter int unsigned TIMEOUT_CYC   = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       transfer,
    input  logic                       write,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata,
    output logic                       ready,
    output logic                       err,
    apb_master_bridge_if.master        apb
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    idx_q;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          ready_nx, err_nx, latch;
    logic [31:0]   rdata_nx;
    logic [31:0]   offset, slot;
    logic          hit;
    logic          sel_ready;
    logic [31:0]   sel_rdata;

    assign offset  = addr - BASE_ADDR;
    assign slot    = offset >> SLV_SIZE_LOG2;
    assign hit     = (addr >= BASE_ADDR) && (slot < 32'd4);
    assign cnt_inc = cnt + CW'(1);

    // Response mux: only the latched slave's PREADY/PRDATA are observed.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        case (idx_q)
            2'd0: begin sel_ready = apb.PREADY0; sel_rdata = apb.PRDATA0; end
            2'd1: begin sel_ready = apb.PREADY1; sel_rdata = apb.PRDATA1; end
            2'd2: begin sel_ready = apb.PREADY2; sel_rdata = apb.PRDATA2; end
            default: begin sel_ready = apb.PREADY3; sel_rdata = apb.PRDATA3; end
        endcase
    end

    // APB select/enable decoded from the current state.
    always_comb begin
        apb.PSEL    = '0;
        apb.PENABLE = (state == ACCESS);
        if (state != IDLE) begin
            apb.PSEL[idx_q] = 1'b1;
        end
    end

    // Next-state and completion logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ready_nx = 1'b0;
        err_nx   = 1'b0;
        rdata_nx = rdata;
        latch    = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    latch = 1'b1;
                    if (hit) begin
                        state_nx = SETUP;
                        cnt_nx   = '0;
                    end else begin
                        // Decode miss: complete with error without touching the bus.
                        ready_nx = 1'b1;
                        err_nx   = 1'b1;
                        rdata_nx = '0;
                    end
                end
            end
            SETUP: begin
                state_nx = ACCESS;
            end
            ACCESS: begin
                cnt_nx = cnt_inc;
                if (sel_ready) begin
                    state_nx = IDLE;
                    ready_nx = 1'b1;
                    rdata_nx = apb.PWRITE ? '0 : sel_rdata;
                end else if (cnt_inc == CW'(TIMEOUT_CYC)) begin
                    state_nx = IDLE;
                    ready_nx = 1'b1;
                    err_nx   = 1'b1;
                    rdata_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request latch, timeout counter and CPU response registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            apb.PADDR  <= '0;
            apb.PWDATA <= '0;
            apb.PWRITE <= 1'b0;
            idx_q      <= '0;
            cnt        <= '0;
            ready      <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            cnt   <= cnt_nx;
            ready <= ready_nx;
            err   <= err_nx;
            rdata <= rdata_nx;
            if (latch) begin
                apb.PADDR  <= addr;
                apb.PWDATA <= wdata;
                apb.PWRITE <= write;
                idx_q      <= slot[1:0];
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with behavioural APB slaves.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_if bus ();

    apb_master_bridge #(
        .BASE_ADDR    (32'h1000_0000),
        .SLV_SIZE_LOG2(12),
        .TIMEOUT_CYC  (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .transfer(transfer),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err),
        .apb     (bus.master)
    );

    // Slave models: per-slave wait states, a "dead" option, and slave 0
    // optionally forced always-ready with fixed data.
    int unsigned waits [4];
    logic        dead  [4];
    logic        force0;
    int unsigned wcnt  [4];
    logic [31:0] mem   [4][1024];
    logic        pr    [4];
    logic [31:0] pd    [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pr[i] = bus.PSEL[i] && bus.PENABLE && !dead[i] && (wcnt[i] >= waits[i]);
            pd[i] = mem[i][bus.PADDR[11:2]];
        end
        if (force0) begin
            pr[0] = 1'b1;
            pd[0] = 32'h1234_5678;
        end
    end

    always_ff @(posedge PCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.PSEL[i] && bus.PENABLE && !pr[i]) wcnt[i] <= wcnt[i] + 1;
            else                                      wcnt[i] <= 0;
            if (bus.PSEL[i] && bus.PENABLE && pr[i] && bus.PWRITE)
                mem[i][bus.PADDR[11:2]] <= bus.PWDATA;
        end
    end

    assign bus.PREADY0 = pr[0];
    assign bus.PREADY1 = pr[1];
    assign bus.PREADY2 = pr[2];
    assign bus.PREADY3 = pr[3];
    assign bus.PRDATA0 = pd[0];
    assign bus.PRDATA1 = pd[1];
    assign bus.PRDATA2 = pd[2];
    assign bus.PRDATA3 = pd[3];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        logic [3:0]  psel;
        int unsigned en;
    } exp_t;

    exp_t sb[$];

    // One CPU request; latency counted from the sampling edge (cycle 1 = SETUP).
    task automatic xfer(input string name, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] erd, input logic eerr,
                        input int unsigned elat, input logic [3:0] epsel, input int unsigned een);
        exp_t        e;
        exp_t        got;
        int unsigned cyc;
        int unsigned en_cnt;
        int unsigned unstable;
        logic [3:0]  seen;
        logic        done;
        e = '{erd, eerr, elat, epsel, een};
        sb.push_back(e);
        @(negedge PCLK);
        transfer = 1'b1; write = wr; addr = a; wdata = d;
        @(negedge PCLK);
        transfer = 1'b0;
        cyc = 1; done = 1'b0; seen = '0; en_cnt = 0; unstable = 0;
        while (!done && cyc <= 60) begin
            seen |= bus.PSEL;
            if (bus.PENABLE) en_cnt++;
            if (bus.PSEL != 4'b0 &&
                (bus.PADDR !== a || bus.PWRITE !== wr || (wr && bus.PWDATA !== d)))
                unstable++;
            if (ready) done = 1'b1;
            else begin
                @(negedge PCLK);
                cyc++;
            end
        end
        got = sb.pop_front();
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: no ready within 60 cycles", name);
        end else begin
            chk({name, " rdata"},   rdata,    got.rdata);
            chk({name, " err"},     32'(err), 32'(got.err));
            chk({name, " latency"}, cyc,      got.lat);
            chk({name, " psel"},    32'(seen), 32'(got.psel));
            chk({name, " enable"},  en_cnt,   got.en);
            chk({name, " stable"},  unstable, 0);
            @(negedge PCLK);
            chk({name, " ready_clr"}, {31'b0, ready, err}, 0);
            chk({name, " rdata_hold"}, rdata, got.rdata);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] erd;
        logic        eerr;
        int unsigned lat;
        logic [3:0]  psel;
        int unsigned en;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned pulses;
        int unsigned mask;

        vecs[0]  = '{1'b1, 32'h1000_0004, 32'h0000_04D2, 32'h0,          1'b0, 4, 4'b0001, 2};
        vecs[1]  = '{1'b0, 32'h1000_0004, 32'h0,          32'h0000_04D2, 1'b0, 4, 4'b0001, 2};
        vecs[2]  = '{1'b1, 32'h1000_0008, 32'h0000_0005, 32'h0,          1'b0, 4, 4'b0001, 2};
        vecs[3]  = '{1'b0, 32'h1000_0008, 32'h0,          32'h0000_0005, 1'b0, 4, 4'b0001, 2};
        vecs[4]  = '{1'b1, 32'h1000_2010, 32'hA5A5_0001, 32'h0,          1'b0, 3, 4'b0100, 1};
        vecs[5]  = '{1'b0, 32'h1000_2010, 32'h0,          32'hA5A5_0001, 1'b0, 3, 4'b0100, 1};
        vecs[6]  = '{1'b1, 32'h1000_1FFC, 32'h0000_0077, 32'h0,          1'b0, 4, 4'b0010, 2};
        vecs[7]  = '{1'b0, 32'h1000_1FFC, 32'h0,          32'h0000_0077, 1'b0, 4, 4'b0010, 2};
        vecs[8]  = '{1'b1, 32'h1000_3FFC, 32'h0000_0003, 32'h0,          1'b0, 3, 4'b1000, 1};
        vecs[9]  = '{1'b0, 32'h1000_3FFC, 32'h0,          32'h0000_0003, 1'b0, 3, 4'b1000, 1};
        vecs[10] = '{1'b0, 32'h1000_4000, 32'h0,          32'h0,          1'b1, 1, 4'b0000, 0};
        vecs[11] = '{1'b1, 32'h0FFF_FFFC, 32'h0000_0009, 32'h0,          1'b1, 1, 4'b0000, 0};
        vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          32'h0,          1'b1, 1, 4'b0000, 0};
        vecs[13] = '{1'b1, 32'h1000_1000, 32'hDEAD_BEEF, 32'h0,          1'b0, 4, 4'b0010, 2};

        waits  = '{1, 1, 0, 0};
        dead   = '{1'b0, 1'b0, 1'b0, 1'b0};
        force0 = 1'b0;
        transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        PRESET = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("reset rdata", rdata, 0);
        chk("reset ready_err", {30'b0, ready, err}, 0);
        chk("reset psel_en", {27'b0, bus.PSEL, bus.PENABLE}, 0);
        chk("reset paddr", bus.PADDR, 0);
        chk("reset pwdata", bus.PWDATA, 0);
        chk("reset pwrite", 32'(bus.PWRITE), 0);
        PRESET = 1'b0;

        for (int i = 0; i < 14; i++) begin
            xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].erd,
                 vecs[i].eerr, vecs[i].lat, vecs[i].psel, vecs[i].en);
        end

        // Timeout on a dead slave; a preceding read leaves rdata non-zero.
        xfer("pre_to", 1'b0, 32'h1000_0008, 32'h0, 32'h5, 1'b0, 4, 4'b0001, 2);
        dead[3] = 1'b1;
        xfer("timeout", 1'b0, 32'h1000_3000, 32'h0, 32'h0, 1'b1, 18, 4'b1000, 16);
        dead[3] = 1'b0;
        chk("timeout psel_idle", 32'(bus.PSEL), 0);

        // Three wait states on slave 1 while slave 0 drives ready/data throughout.
        waits[1] = 3;
        force0   = 1'b1;
        xfer("waitst", 1'b0, 32'h1000_1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 6, 4'b0010, 4);
        force0   = 1'b0;
        waits[1] = 1;

        // Asynchronous reset during ACCESS.
        waits[2] = 5;
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_2020; wdata = 32'h0000_1111;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        chk("rst access_en", 32'(bus.PENABLE), 1);
        #2 PRESET = 1'b1;
        #1;
        chk("rst async psel_en", {27'b0, bus.PSEL, bus.PENABLE}, 0);
        chk("rst async ready", 32'(ready), 0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge PCLK);
            if (ready || bus.PSEL != 4'b0) pulses++;
        end
        chk("rst no_ready", pulses, 0);
        waits[2] = 0;
        xfer("post_rst", 1'b0, 32'h1000_2010, 32'h0, 32'hA5A5_0001, 1'b0, 3, 4'b0100, 1);

        // transfer held high: ignored in SETUP/ACCESS, accepted in the ready cycle.
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2010; wdata = '0;
        mask = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge PCLK);
            if (c == 4) transfer = 1'b0;
            if (ready) mask |= (32'd1 << c);
        end
        chk("b2b ready_cycles", mask, 32'h48);
        chk("b2b rdata", rdata, 32'hA5A5_0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
